// File: rtl/apb_slot_ctrl.sv
// APB3 bridge from the MSS master to four downstream APB slots plus a local status/config register bank.
// Build option: define APB_SLOT_TIMEOUT_EN to include the per-access slot watchdog.
module apb_slot_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [3:0]  SLOT_EN_RST    = 4'hF
) (
    input  logic         FAB_CLK,
    input  logic         M2F_RESET_N,
    input  logic         MSSPSEL,
    input  logic         MSSPENABLE,
    input  logic         MSSPWRITE,
    input  logic [19:0]  MSSPADDR,
    input  logic [31:0]  MSSPWDATA,
    output logic [31:0]  MSSPRDATA,
    output logic         MSSPREADY,
    output logic         MSSPSLVERR,
    output logic [3:0]   S_PSEL,
    output logic         S_PENABLE,
    output logic         S_PWRITE,
    output logic [7:0]   S_PADDR,
    output logic [31:0]  S_PWDATA,
    input  logic [127:0] S_PRDATA,
    input  logic [3:0]   S_PREADY,
    input  logic [3:0]   S_PSLVERR
);
    // state  | meaning
    // IDLE   | waiting for an upstream setup phase
    // SETUP  | request latched; downstream setup phase or local/unmapped decode
    // ACCESS | downstream access phase, waiting on the selected slot's PREADY
    // RESP   | single upstream completion cycle driven from the response latches

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t      state, nxt_state;
    logic [19:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [1:0]  slot_q;
    logic [31:0] rdata_q, rsp_rdata, reg_rdata, slot_rdata;
    logic        slverr_q, rsp_err, rsp_load;
    logic [7:0]  status_q, status_d;
    logic [19:0] last_err_q, last_err_d;
    logic [15:0] err_count, err_count_d;
    logic [3:0]  slot_en_q, slot_en_d;
    logic        is_slot, is_int, ds_go, reg_wr;
    logic        err_evt, ds_err_evt, to_evt, to_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    assign slot_q     = addr_q[9:8];
    assign is_slot    = ~addr_q[10];
    assign is_int     = (addr_q[10:8] == 3'b111);
    assign ds_go      = is_slot & slot_en_q[slot_q];
    assign slot_rdata = S_PRDATA[{slot_q, 5'd0} +: 32];

`ifdef APB_SLOT_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt;

    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N || state != ACCESS)
            to_cnt <= '0;
        else if (!S_PREADY[slot_q])
            to_cnt <= to_cnt + 8'd1;
    end

    assign to_hit = (to_cnt == TO_LAST);
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        reg_rdata = '0;
        case (addr_q[3:2])
            2'd0:    reg_rdata = {24'd0, status_q};
            2'd1:    reg_rdata = {12'd0, last_err_q};
            2'd2:    reg_rdata = {16'd0, err_count};
            default: reg_rdata = {28'd0, slot_en_q};
        endcase
    end

    always_comb begin
        nxt_state  = state;
        rsp_load   = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        reg_wr     = 1'b0;
        err_evt    = 1'b0;
        ds_err_evt = 1'b0;
        to_evt     = 1'b0;
        case (state)
            IDLE: if (MSSPSEL && !MSSPENABLE) nxt_state = SETUP;
            SETUP: begin
                if (!MSSPSEL) begin
                    nxt_state = IDLE;
                end else if (ds_go) begin
                    nxt_state = ACCESS;
                end else begin
                    nxt_state = RESP;
                    rsp_load  = 1'b1;
                    if (is_int) begin
                        reg_wr    = write_q;
                        rsp_rdata = write_q ? 32'd0 : reg_rdata;
                    end else begin
                        rsp_err = 1'b1;
                        err_evt = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (!MSSPSEL) begin
                    nxt_state = IDLE;
                end else if (S_PREADY[slot_q]) begin
                    nxt_state  = RESP;
                    rsp_load   = 1'b1;
                    rsp_rdata  = slot_rdata;
                    rsp_err    = S_PSLVERR[slot_q];
                    err_evt    = S_PSLVERR[slot_q];
                    ds_err_evt = S_PSLVERR[slot_q];
                end else if (to_hit) begin
                    nxt_state = RESP;
                    rsp_load  = 1'b1;
                    rsp_err   = 1'b1;
                    err_evt   = 1'b1;
                    to_evt    = 1'b1;
                end
            end
            RESP:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Error events are applied after register writes so they win on coincidence.
    always_comb begin
        status_d    = status_q;
        last_err_d  = last_err_q;
        err_count_d = err_count;
        slot_en_d   = slot_en_q;
        if (reg_wr) begin
            case (addr_q[3:2])
                2'd0:    status_d = status_q & ~wdata_q[7:0];
                2'd2:    err_count_d = '0;
                2'd3:    slot_en_d = wdata_q[3:0];
                default: ;
            endcase
        end
        if (to_evt)     status_d[{1'b0, slot_q}] = 1'b1;
        if (ds_err_evt) status_d[{1'b1, slot_q}] = 1'b1;
        if (err_evt) begin
            last_err_d = addr_q;
            if (err_count != 16'hFFFF) err_count_d = err_count + 16'd1;
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            rdata_q    <= '0;
            slverr_q   <= 1'b0;
            status_q   <= '0;
            last_err_q <= '0;
            err_count  <= '0;
            slot_en_q  <= SLOT_EN_RST;
        end else begin
            state <= nxt_state;
            if (state == IDLE && nxt_state == SETUP) begin
                addr_q  <= MSSPADDR;
                wdata_q <= MSSPWDATA;
                write_q <= MSSPWRITE;
            end
            if (rsp_load) begin
                rdata_q  <= rsp_rdata;
                slverr_q <= rsp_err;
            end
            status_q   <= status_d;
            last_err_q <= last_err_d;
            err_count  <= err_count_d;
            slot_en_q  <= slot_en_d;
        end
    end

    always_comb begin
        S_PSEL = '0;
        if ((state == SETUP && ds_go) || state == ACCESS) S_PSEL[slot_q] = 1'b1;
    end

    assign S_PENABLE  = (state == ACCESS);
    assign S_PWRITE   = write_q;
    assign S_PADDR    = addr_q[7:0];
    assign S_PWDATA   = wdata_q;
    assign MSSPREADY  = (state == RESP);
    assign MSSPRDATA  = MSSPREADY ? rdata_q : 32'd0;
    assign MSSPSLVERR = MSSPREADY & slverr_q;

endmodule
